// File: rtl/shift_unit.sv
// Multi-cycle shifter (SLL/SRL/SRA, optional ROR) moving one bit position per clock.
// Define SHIFT_ROTATE_EN to build the rotate datapath; otherwise MODE=11 is a pass-through.
module shift_unit #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               START,
   input  logic [1:0]         MODE,
   input  logic [WIDTH-1:0]   DATA_IN,
   input  logic [SHAMT_W-1:0] SHAMT,
   output logic               BUSY,
   output logic               DONE,
   output logic [WIDTH-1:0]   RESULT,
   output logic               ZERO,
   output logic [1:0]         DBG_STATE
);

   localparam int LW = $clog2(WIDTH);
   localparam int CW = LW + 1;
   localparam logic [SHAMT_W:0] WIDTH_S = (SHAMT_W + 1)'(WIDTH);
   localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_FIN   = 2'd2
   } state_t;

   // Handshake: START is sampled only in IDLE/FIN; BUSY is high exactly in SHIFT;
   // DONE is a one-cycle pulse in FIN, when RESULT/ZERO have just been updated.
   state_t           state_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] work_d;
   logic [WIDTH-1:0] result_q;
   logic [1:0]       mode_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             busy_q;
   logic             done_q;
   logic             zero_q;
   logic [SHAMT_W:0] shamt_ext;

   assign shamt_ext = {1'b0, SHAMT};

   // Effective amount: linear shifts saturate at WIDTH, rotate wraps modulo WIDTH.
   always_comb begin
      count_d = (shamt_ext >= WIDTH_S) ? WIDTH_C : shamt_ext[CW-1:0];
      if (MODE == 2'b11) begin
`ifdef SHIFT_ROTATE_EN
         count_d = {1'b0, SHAMT[LW-1:0]};
`else
         count_d = '0;
`endif
      end
   end

   always_comb begin
      work_d = work_q;
      case (mode_q)
         2'b00:   work_d = {work_q[WIDTH-2:0], 1'b0};
         2'b01:   work_d = {1'b0, work_q[WIDTH-1:1]};
         2'b10:   work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
         2'b11:   work_d = {work_q[0], work_q[WIDTH-1:1]};
`endif
         default: work_d = work_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         work_q   <= '0;
         mode_q   <= 2'b00;
         count_q  <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         zero_q   <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_FIN: begin
               if (START) begin
                  state_q <= S_SHIFT;
                  work_q  <= DATA_IN;
                  mode_q  <= MODE;
                  count_q <= count_d;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_SHIFT: begin
               if (count_q != '0) begin
                  work_q  <= work_d;
                  count_q <= count_q - CW'(1);
               end else begin
                  state_q  <= S_FIN;
                  result_q <= work_q;
                  zero_q   <= (work_q == '0);
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign RESULT    = result_q;
   assign ZERO      = zero_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit (WIDTH=8, SHAMT_W=8); rotate expectations follow SHIFT_ROTATE_EN.
module tb_shift_unit;

   logic       CLK;
   logic       RESET;
   logic       START;
   logic [1:0] MODE;
   logic [7:0] DATA_IN;
   logic [7:0] SHAMT;
   logic       BUSY;
   logic       DONE;
   logic [7:0] RESULT;
   logic       ZERO;
   logic [1:0] DBG_STATE;

   int n_cmp = 0;
   int n_err = 0;

   shift_unit #(.WIDTH(8), .SHAMT_W(8)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .START     (START),
      .MODE      (MODE),
      .DATA_IN   (DATA_IN),
      .SHAMT     (SHAMT),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .RESULT    (RESULT),
      .ZERO      (ZERO),
      .DBG_STATE (DBG_STATE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Present an operation and step past the accepting edge (edge 1).
   task automatic start_op(input logic [1:0] m, input logic [7:0] d, input logic [7:0] s,
                           input bit hold);
      MODE = m; DATA_IN = d; SHAMT = s; START = 1'b1;
      @(posedge CLK); #1;
      if (!hold) START = 1'b0;
   endtask

   // Step edges until DONE (bounded); cyc is the edge number where DONE was seen.
   task automatic wait_done(input int first, input int budget, output int cyc, output int busy_cnt);
      cyc = first;
      busy_cnt = BUSY ? 1 : 0;
      while (!DONE && cyc < budget) begin
         @(posedge CLK); #1;
         cyc++;
         if (BUSY) busy_cnt++;
      end
   endtask

   task automatic test_reset;
      RESET = 1'b1; START = 1'b0; MODE = 2'b00; DATA_IN = 8'h00; SHAMT = 8'h00;
      repeat (2) @(posedge CLK);
      #1;
      n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
      n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", DONE); end
      n_cmp++; if (RESULT !== 8'h00) begin n_err++; $display("FAIL reset_result: got %h want 00", RESULT); end
      n_cmp++; if (ZERO !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b want 1", ZERO); end
      n_cmp++; if (DBG_STATE !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", DBG_STATE); end
      RESET = 1'b0;
   endtask

   task automatic test_sra;
      int cyc, bc;
      start_op(2'b10, 8'h96, 8'd3, 1'b0);
      wait_done(1, 20, cyc, bc);
      n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL sra_latency: got edge %0d want 5", cyc); end
      n_cmp++; if (bc !== 4) begin n_err++; $display("FAIL sra_busy_cycles: got %0d want 4", bc); end
      n_cmp++; if (RESULT !== 8'hF2) begin n_err++; $display("FAIL sra_result: got %h want f2", RESULT); end
      n_cmp++; if (ZERO !== 1'b0) begin n_err++; $display("FAIL sra_zero: got %b want 0", ZERO); end
      n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL sra_busy_fin: got %b want 0", BUSY); end
      @(posedge CLK); #1;
      n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL sra_done_pulse: got %b want 0", DONE); end
   endtask

   task automatic test_saturate;
      int cyc, bc;
      start_op(2'b01, 8'h96, 8'd200, 1'b0);
      wait_done(1, 30, cyc, bc);
      n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL srl_sat_latency: got edge %0d want 10", cyc); end
      n_cmp++; if (RESULT !== 8'h00) begin n_err++; $display("FAIL srl_sat_result: got %h want 00", RESULT); end
      n_cmp++; if (ZERO !== 1'b1) begin n_err++; $display("FAIL srl_sat_zero: got %b want 1", ZERO); end
      start_op(2'b10, 8'h80, 8'd9, 1'b0);
      wait_done(1, 30, cyc, bc);
      n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL sra_sat_latency: got edge %0d want 10", cyc); end
      n_cmp++; if (RESULT !== 8'hFF) begin n_err++; $display("FAIL sra_sat_result: got %h want ff", RESULT); end
      n_cmp++; if (ZERO !== 1'b0) begin n_err++; $display("FAIL sra_sat_zero: got %b want 0", ZERO); end
      start_op(2'b00, 8'h81, 8'd1, 1'b0);
      wait_done(1, 30, cyc, bc);
      n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL sll_latency: got edge %0d want 3", cyc); end
      n_cmp++; if (RESULT !== 8'h02) begin n_err++; $display("FAIL sll_result: got %h want 02", RESULT); end
   endtask

   task automatic test_rotate;
      int cyc, bc;
      int exp_cyc;
      logic [7:0] exp_res;
`ifdef SHIFT_ROTATE_EN
      exp_cyc = 5; exp_res = 8'hD2;
`else
      exp_cyc = 2; exp_res = 8'h96;
`endif
      start_op(2'b11, 8'h96, 8'd11, 1'b0);
      wait_done(1, 30, cyc, bc);
      n_cmp++; if (cyc !== exp_cyc) begin n_err++; $display("FAIL ror_latency: got edge %0d want %0d", cyc, exp_cyc); end
      n_cmp++; if (RESULT !== exp_res) begin n_err++; $display("FAIL ror_result: got %h want %h", RESULT, exp_res); end
   endtask

   task automatic test_back_to_back;
      int cyc, bc;
      start_op(2'b00, 8'h5A, 8'd0, 1'b1);
      // Next operation is presented while START stays high; it must not disturb the first.
      MODE = 2'b01; DATA_IN = 8'h80; SHAMT = 8'd1;
      n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL b2b_busy_e1: got %b want 1", BUSY); end
      @(posedge CLK); #1;
      n_cmp++; if (DONE !== 1'b1) begin n_err++; $display("FAIL b2b_done_e2: got %b want 1", DONE); end
      n_cmp++; if (RESULT !== 8'h5A) begin n_err++; $display("FAIL b2b_first_result: got %h want 5a", RESULT); end
      @(posedge CLK); #1;
      START = 1'b0;
      n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL b2b_no_gap: got busy %b want 1", BUSY); end
      n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL b2b_done_e3: got %b want 0", DONE); end
      wait_done(1, 20, cyc, bc);
      n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL b2b_second_latency: got edge %0d want 3", cyc); end
      n_cmp++; if (RESULT !== 8'h40) begin n_err++; $display("FAIL b2b_second_result: got %h want 40", RESULT); end
   endtask

   task automatic test_ignore_start;
      int cyc, bc, dc;
      start_op(2'b01, 8'h96, 8'd4, 1'b0);
      @(posedge CLK); #1;
      START = 1'b1; DATA_IN = 8'hFF; MODE = 2'b00; SHAMT = 8'd1;
      @(posedge CLK); #1;
      START = 1'b0;
      n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL ign_busy: got %b want 1", BUSY); end
      wait_done(3, 30, cyc, bc);
      n_cmp++; if (cyc !== 6) begin n_err++; $display("FAIL ign_latency: got edge %0d want 6", cyc); end
      n_cmp++; if (RESULT !== 8'h09) begin n_err++; $display("FAIL ign_result: got %h want 09", RESULT); end
      dc = DONE ? 1 : 0;
      repeat (4) begin
         @(posedge CLK); #1;
         if (DONE) dc++;
      end
      n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", dc); end
      n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL ign_idle_busy: got %b want 0", BUSY); end
   endtask

   task automatic test_reset_mid;
      int cyc, bc, dc;
      start_op(2'b10, 8'h96, 8'd5, 1'b0);
      @(posedge CLK); #1;
      RESET = 1'b1; START = 1'b1;
      @(posedge CLK); #1;
      n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", BUSY); end
      n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b want 0", DONE); end
      n_cmp++; if (RESULT !== 8'h00) begin n_err++; $display("FAIL rst_mid_result: got %h want 00", RESULT); end
      n_cmp++; if (ZERO !== 1'b1) begin n_err++; $display("FAIL rst_mid_zero: got %b want 1", ZERO); end
      n_cmp++; if (DBG_STATE !== 2'd0) begin n_err++; $display("FAIL rst_mid_state: got %0d want 0", DBG_STATE); end
      RESET = 1'b0; START = 1'b0;
      dc = 0;
      repeat (8) begin
         @(posedge CLK); #1;
         if (DONE) dc++;
      end
      n_cmp++; if (dc !== 0) begin n_err++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", dc); end
      start_op(2'b00, 8'h01, 8'd2, 1'b0);
      wait_done(1, 20, cyc, bc);
      n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL rst_after_latency: got edge %0d want 4", cyc); end
      n_cmp++; if (RESULT !== 8'h04) begin n_err++; $display("FAIL rst_after_result: got %h want 04", RESULT); end
      n_cmp++; if (ZERO !== 1'b0) begin n_err++; $display("FAIL rst_after_zero: got %b want 0", ZERO); end
   endtask

   initial begin
      test_reset;
      test_sra;
      test_saturate;
      test_rotate;
      test_back_to_back;
      test_ignore_start;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule
